// File: rtl/rw_stage.sv
// Register-writeback stage: MA/RW pipeline latch, writeback result mux,
// 16-entry register file with two bypassed read ports, retired-instruction counter.
module rw_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4,
    parameter int RA_IDX = 15
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_ldResult,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_isWb,
    input  logic              in_isLd,
    input  logic              in_isCall,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired_count
);

    logic              v_q, v_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              is_wb_q, is_wb_d;
    logic              is_ld_q, is_ld_d;
    logic              is_call_q, is_call_d;
    logic [31:0]       count_q, count_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    always_comb begin
        wb_valid = v_q & (is_wb_q | is_call_q);
        if (is_call_q) begin
            wb_data = pc_q + DATA_W'(4);
            wb_addr = ADDR_W'(RA_IDX);
        end else if (is_ld_q) begin
            wb_data = ld_q;
            wb_addr = rd_q;
        end else begin
            wb_data = alu_q;
            wb_addr = rd_q;
        end
    end

    always_comb begin
        v_d       = v_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        ld_d      = ld_q;
        rd_d      = rd_q;
        is_wb_d   = is_wb_q;
        is_ld_d   = is_ld_q;
        is_call_d = is_call_q;
        count_d   = count_q;
        rf_d      = rf_q;
        if (!stall) begin
            // Commit the latched instruction, then capture the incoming one.
            if (wb_valid) rf_d[wb_addr] = wb_data;
            if (v_q) count_d = count_q + 32'd1;
            v_d       = in_valid & ~flush;
            pc_d      = in_pc;
            alu_d     = in_aluResult;
            ld_d      = in_ldResult;
            rd_d      = in_rd;
            is_wb_d   = in_isWb;
            is_ld_d   = in_isLd;
            is_call_d = in_isCall;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            v_q       <= 1'b0;
            pc_q      <= '0;
            alu_q     <= '0;
            ld_q      <= '0;
            rd_q      <= '0;
            is_wb_q   <= 1'b0;
            is_ld_q   <= 1'b0;
            is_call_q <= 1'b0;
            count_q   <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            v_q       <= v_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            ld_q      <= ld_d;
            rd_q      <= rd_d;
            is_wb_q   <= is_wb_d;
            is_ld_q   <= is_ld_d;
            is_call_q <= is_call_d;
            count_q   <= count_d;
            rf_q      <= rf_d;
        end
    end

    assign rs1_data      = (wb_valid && wb_addr == rs1_addr) ? wb_data : rf_q[rs1_addr];
    assign rs2_data      = (wb_valid && wb_addr == rs2_addr) ? wb_data : rf_q[rs2_addr];
    assign retired_count = count_q;

endmodule

// File: tb/tb_rw_stage.sv
// Scoreboard bench for rw_stage: stimulus pushes expected observations from a
// behavioural model; a negedge monitor pops and compares them.
module tb_rw_stage;

    logic        Clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, flush;
    logic [31:0] in_pc, in_aluResult, in_ldResult;
    logic [3:0]  in_rd;
    logic        in_isWb, in_isLd, in_isCall;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retired_count;

    rw_stage #(.DATA_W(32), .NREG(16), .ADDR_W(4), .RA_IDX(15)) dut (
        .Clk(Clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_pc(in_pc), .in_aluResult(in_aluResult), .in_ldResult(in_ldResult),
        .in_rd(in_rd), .in_isWb(in_isWb), .in_isLd(in_isLd), .in_isCall(in_isCall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .retired_count(retired_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          wv;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [31:0] cnt;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;

    // Reference model: architectural registers plus the one pending writeback.
    logic [31:0] m_rf [16];
    bit          m_v, m_wr;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_v = 0; m_wr = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (m_v && m_wr && m_addr == a) return m_data;
        return m_rf[a];
    endfunction

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rs1_data", rs1_data, e.r1);
            chk("rs2_data", rs2_data, e.r2);
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wv});
            chk("retired_count", retired_count, e.cnt);
            if (e.wv) begin
                chk("wb_addr", {28'd0, wb_addr}, {28'd0, e.wa});
                chk("wb_data", wb_data, e.wd);
            end
        end
    end

    // Drive one cycle: inputs set just after an edge, expectation for the current
    // state pushed, then the model advances across the next rising edge.
    task automatic step(input bit iv, input bit st, input bit fl,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ld,
                        input logic [3:0] rd, input bit wb, input bit isld, input bit call,
                        input logic [3:0] a1, input logic [3:0] a2);
        exp_t e;
        in_valid = iv; stall = st; flush = fl; in_pc = pc; in_aluResult = alu;
        in_ldResult = ld; in_rd = rd; in_isWb = wb; in_isLd = isld; in_isCall = call;
        rs1_addr = a1; rs2_addr = a2;
        e.wv = m_v && m_wr; e.wa = m_addr; e.wd = m_data; e.cnt = m_cnt;
        e.r1 = model_read(a1); e.r2 = model_read(a2);
        q.push_back(e);
        @(posedge Clk);
        if (!st) begin
            if (m_v && m_wr) m_rf[m_addr] = m_data;
            if (m_v) m_cnt = m_cnt + 1;
            m_v    = iv && !fl;
            m_wr   = wb || call;
            m_addr = call ? 4'd15 : rd;
            m_data = call ? pc + 32'd4 : (isld ? ld : alu);
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 0, 0, 0, a1, a2);
    endtask

    task automatic check_reset_state();
        rs1_addr = 4'($urandom_range(0, 15));
        rs2_addr = 4'($urandom_range(0, 15));
        #1;
        chk("reset rs1_data", rs1_data, 32'h0);
        chk("reset rs2_data", rs2_data, 32'h0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'h0);
        chk("reset wb_addr", {28'd0, wb_addr}, 32'h0);
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset retired_count", retired_count, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; stall = 0; flush = 0; in_pc = '0; in_aluResult = '0; in_ldResult = '0;
        in_rd = '0; in_isWb = 0; in_isLd = 0; in_isCall = 0; rs1_addr = '0; rs2_addr = '0;
        model_reset();
        check_reset_state();
        @(posedge Clk); #1;
        reset = 1'b0;

        // ALU writeback, then read back via bypass and RF
        step(1, 0, 0, 32'h0, 32'h0000_1234, 32'h0, 4'd3, 1, 0, 0, 4'd3, 4'd0);
        idle(4'd3, 4'd3);
        idle(4'd3, 4'd1);
        // load select vs alu select
        step(1, 0, 0, 32'h0, 32'h40, 32'hDEAD_BEEF, 4'd5, 1, 1, 0, 4'd5, 4'd3);
        step(1, 0, 0, 32'h0, 32'h40, 32'hDEAD_BEEF, 4'd5, 1, 0, 0, 4'd5, 4'd5);
        idle(4'd5, 4'd3);
        // call writes pc+4 to r15, including wrap
        step(1, 0, 0, 32'h0000_0100, 32'h77, 32'h88, 4'd2, 1, 0, 1, 4'd15, 4'd2);
        idle(4'd15, 4'd2);
        step(1, 0, 0, 32'hFFFF_FFFC, 32'h77, 32'h88, 4'd2, 0, 1, 1, 4'd15, 4'd2);
        idle(4'd15, 4'd2);
        // stall holds the pending write; flush drops only the incoming instruction
        step(1, 0, 0, 32'h0, 32'd9, 32'h0, 4'd7, 1, 0, 0, 4'd7, 4'd8);
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1, 0, 0, 4'd7, 4'd8);
        step(1, 0, 1, 32'h0, 32'd1, 32'h0, 4'd8, 1, 0, 0, 4'd7, 4'd8);
        idle(4'd7, 4'd8);
        idle(4'd7, 4'd8);
        // back-to-back writes to the same register
        step(1, 0, 0, 32'h0, 32'd1, 32'h0, 4'd4, 1, 0, 0, 4'd4, 4'd4);
        step(1, 0, 0, 32'h0, 32'd2, 32'h0, 4'd4, 1, 0, 0, 4'd4, 4'd4);
        idle(4'd4, 4'd4);
        // valid instruction without writeback counts but leaves the RF alone
        step(1, 0, 0, 32'h0, 32'hFFFF, 32'hEEEE, 4'd4, 0, 0, 0, 4'd4, 4'd0);
        idle(4'd4, 4'd0);
        // invalid latch with wb/call set: no write, no count
        step(0, 0, 0, 32'h200, 32'hABCD, 32'h0, 4'd0, 1, 0, 1, 4'd0, 4'd15);
        idle(4'd0, 4'd15);

        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 300; i++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            // reset mid-run with a pending write and possibly a stall active
            step(1, 1, 0, 32'h0, 32'h5A5A, 32'h0, 4'd6, 1, 0, 0, 4'd6, 4'd15);
            @(negedge Clk); #1;
            reset = 1'b1;
            model_reset();
            check_reset_state();
            @(posedge Clk); #1;
            reset = 1'b0;
            idle(4'd6, 4'd15);
        end

        repeat (3) @(negedge Clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
